// File: rtl/ahb_resp_mux.sv
// AHB-Lite slave-to-master response multiplexer with a built-in default slave.
// Address-phase HSEL is registered into a one-hot data-phase select that steers HRDATA/HREADY/HRESP.
module ahb_resp_mux #(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             hclk,
  input  logic                             hreset,
  input  logic [NUM_SLAVES-1:0]            hsel,
  input  logic [1:0]                       htrans,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s,
  input  logic [NUM_SLAVES-1:0]            hreadyout_s,
  input  logic [NUM_SLAVES-1:0]            hresp_s,
  output logic [DATA_WIDTH-1:0]            hrdata,
  output logic                             hready,
  output logic                             hresp,
  output logic                             multi_sel_err
);

  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    DEF_IDLE = 2'd0,
    DEF_ERR1 = 2'd1,
    DEF_ERR2 = 2'd2
  } def_state_t;

  def_state_t              def_state;
  def_state_t              def_state_nxt;
  logic [NUM_SLAVES:0]     dsel;
  logic [NUM_SLAVES:0]     dsel_nxt;
  logic                    sel_none;
  logic                    sel_multi;
  logic                    sel_seen;
  logic                    xfer_active;
  logic                    def_err_start;
  logic                    def_ready;
  logic                    def_resp;

  // Decode the address-phase select: none, exactly one, or more than one bit set.
  always_comb begin
    sel_seen  = 1'b0;
    sel_multi = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_multi = sel_multi | (sel_seen & hsel[i]);
      sel_seen  = sel_seen | hsel[i];
    end
    sel_none = ~sel_seen;
  end

  assign xfer_active   = (htrans == HT_NONSEQ) || (htrans == HT_SEQ);
  // A multi-select is an ERROR regardless of htrans.
  assign def_err_start = sel_multi | (sel_none & xfer_active);

  always_comb begin
    dsel_nxt = '0;
    if (sel_none || sel_multi) dsel_nxt[NUM_SLAVES] = 1'b1;
    else                       dsel_nxt[NUM_SLAVES-1:0] = hsel;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dsel          <= '0;
      dsel[NUM_SLAVES] <= 1'b1;
      multi_sel_err <= 1'b0;
    end else begin
      if (hready) dsel <= dsel_nxt;
      multi_sel_err <= hready & sel_multi;
    end
  end

  // Default slave: two-cycle ERROR (wait+ERROR, then ready+ERROR).
  always_ff @(posedge hclk) begin
    if (hreset) def_state <= DEF_IDLE;
    else        def_state <= def_state_nxt;
  end

  always_comb begin
    def_state_nxt = def_state;
    case (def_state)
      DEF_IDLE, DEF_ERR2: def_state_nxt = (hready && def_err_start) ? DEF_ERR1 : DEF_IDLE;
      DEF_ERR1:           def_state_nxt = DEF_ERR2;
      default:            def_state_nxt = DEF_IDLE;
    endcase
  end

  assign def_ready = (def_state != DEF_ERR1);
  assign def_resp  = (def_state != DEF_IDLE);

  // dsel is one-hot, so an AND-OR mux suffices.
  always_comb begin
    hrdata = '0;
    hready = 1'b0;
    hresp  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel[i]) begin
        hrdata = hrdata | hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
        hready = hready | hreadyout_s[i];
        hresp  = hresp | hresp_s[i];
      end
    end
    if (dsel[NUM_SLAVES]) begin
      hready = hready | def_ready;
      hresp  = hresp | def_resp;
    end
  end

endmodule
